ram_bist_ctrl: RTL and testbench

Self-test initiator for the single-port RAM used in the lab top level. On a `start` pulse it drives the RAM's `wen`/`ren`/`ads`/`in` pins to fill every address with a seeded pattern, then reads every address back through the RAM's `out` port and compares each word. It reports busy, done, pass/fail, the first failing address and an error count, which the seven-segment display can show.

---
 rtl/ram_bist_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - single-port RAM self-test initiator (write pattern, read back, count mismatches)
// Optional inverted second pass: define RAM_BIST_INV_PASS_EN.
module ram_bist_ctrl #(
  parameter int datawidth = 8,
  parameter int adswidth  = 4,
  parameter int depth     = 1 << adswidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [datawidth-1:0]  seed,
  output logic                  wen,
  output logic                  ren,
  output logic [adswidth-1:0]   ads,
  output logic [datawidth-1:0]  wdata,
  input  logic [datawidth-1:0]  rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [adswidth-1:0]   err_ads,
  output logic [adswidth+1:0]   err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [adswidth-1:0] L_LAST = adswidth'(depth - 1);

  state_t                 r_state;
  logic [datawidth-1:0]   r_seed;
  logic                   r_wen;
  logic                   r_ren;
  logic [adswidth-1:0]    r_ads;
  logic [datawidth-1:0]   r_wdata;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [adswidth-1:0]    r_err_ads;
  logic [adswidth+1:0]    r_err_cnt;
  logic                   w_inv;
  logic [adswidth-1:0]    w_ads_inc;
  logic                   w_mismatch;

  function automatic logic [datawidth-1:0] f_pat(input logic [adswidth-1:0]  a,
                                                 input logic [datawidth-1:0] s,
                                                 input logic                 inv);
    logic [datawidth+adswidth-1:0] w_ext;
    w_ext = {{datawidth{1'b0}}, a};
    return (w_ext[datawidth-1:0] ^ s) ^ {datawidth{inv}};
  endfunction

`ifdef RAM_BIST_INV_PASS_EN
  logic r_inv;
  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  assign w_ads_inc = r_ads + 1'b1;
  // rdata now holds the word read for the address issued in the previous cycle
  assign w_mismatch = r_ren && (rdata != f_pat(r_ads, r_seed, w_inv));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_seed    <= '0;
      r_wen     <= 1'b0;
      r_ren     <= 1'b0;
      r_ads     <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_ads <= '0;
      r_err_cnt <= '0;
`ifdef RAM_BIST_INV_PASS_EN
      r_inv     <= 1'b0;
`endif
    end else begin
      if (w_mismatch) begin
        if (r_err_cnt == '0) r_err_ads <= r_ads;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_WRITE;
            r_seed    <= seed;
            r_wen     <= 1'b1;
            r_ads     <= '0;
            r_wdata   <= f_pat('0, seed, 1'b0);
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_ads <= '0;
            r_err_cnt <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            r_inv     <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (r_ads == L_LAST) begin
            r_state <= S_READ;
            r_wen   <= 1'b0;
            r_ren   <= 1'b1;
            r_ads   <= '0;
            r_wdata <= '0;
          end else begin
            r_ads   <= w_ads_inc;
            r_wdata <= f_pat(w_ads_inc, r_seed, w_inv);
          end
        end
        S_READ: begin
          if (r_ads == L_LAST) begin
            r_state <= S_CHECK;
            r_ren   <= 1'b0;
            r_ads   <= '0;
          end else begin
            r_ads <= w_ads_inc;
          end
        end
        S_CHECK: begin
`ifdef RAM_BIST_INV_PASS_EN
          if (!r_inv) begin
            r_inv   <= 1'b1;
            r_state <= S_WRITE;
            r_wen   <= 1'b1;
            r_ads   <= '0;
            r_wdata <= f_pat('0, r_seed, 1'b1);
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_cnt == '0);
          end
`else
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == '0);
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wen     = r_wen;
  assign ren     = r_ren;
  assign ads     = r_ads;
  assign wdata   = r_wdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_ads = r_err_ads;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - scoreboard bench for ram_bist_ctrl with a faultable RAM model
module tb_ram_bist_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
  localparam int LAT = 4 * DEPTH + 2;
`else
  localparam int NPASS = 1;
  localparam int LAT = 2 * DEPTH + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic wen, ren, busy, done, pass;
  logic [AW-1:0] ads, err_ads;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic [AW+1:0] err_cnt;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.datawidth(DW), .adswidth(AW), .depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .wen(wen), .ren(ren), .ads(ads), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .pass(pass), .err_ads(err_ads), .err_cnt(err_cnt)
  );

  // RAM samples on negedge; per-address AND/OR masks model stuck-at bits on read
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] f_and [DEPTH];
  logic [DW-1:0] f_or  [DEPTH];
  always @(negedge clk) begin
    if (wen) mem[ads] <= wdata;
    if (ren) rdata <= (mem[ads] & f_and[ads]) | f_or[ads];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int c; int cnt; int ea; logic ps; } res_t;
  wr_t  wq[$];
  res_t rq[$];

  // Monitor: every RAM write and every DONE entry is checked against the queued expectation
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (wen && ren) chk("wen_ren_exclusive", 1, 0);
    if (wen) begin
      if (wq.size() == 0) chk("unexpected_write", {ads, wdata}, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_ads", ads, e.a);
        chk("write_wdata", wdata, e.d);
      end
    end
    if (done && !prev_done) begin
      if (rq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        res_t r;
        r = rq.pop_front();
        chk("done_cycle", cyc, r.c);
        chk("err_cnt", err_cnt, r.cnt);
        chk("err_ads", err_ads, r.ea);
        chk("pass", pass, r.ps);
        chk("busy_at_done", busy, 0);
      end
    end
    prev_done <= done;
  end

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      f_and[a] = '1;
      f_or[a] = '0;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {wen, ren, busy, done, pass, ads, wdata, err_ads, err_cnt}, 0);
  endtask

  // Reference model: writes expected and final result derived from the pattern rule
  task automatic push_model(input logic [DW-1:0] s, input int sc);
    int cnt = 0;
    int ea = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [DW-1:0] w, rd;
        wr_t e;
        w = (DW'(a) ^ s) ^ (p == 1 ? 8'hFF : 8'h00);
        e.a = AW'(a);
        e.d = w;
        wq.push_back(e);
        rd = (w & f_and[a]) | f_or[a];
        if (rd != w) begin
          if (cnt == 0) ea = a;
          if (cnt < 63) cnt++;
        end
      end
    end
    rq.push_back('{c: sc + 1 + LAT, cnt: cnt, ea: ea, ps: (cnt == 0)});
  endtask

  task automatic pulse_start(input logic [DW-1:0] s);
    @(negedge clk);
    start = 1'b1;
    seed = s;
    push_model(s, cyc);
    @(negedge clk);
    start = 1'b0;
    seed = DW'($urandom);
    chk("busy_after_start", busy, 1);
    chk("done_cleared_on_start", done, 0);
    chk("err_cnt_cleared_on_start", err_cnt, 0);
  endtask

  task automatic run_test(input logic [DW-1:0] s, input int restart_at, input logic [DW-1:0] s2);
    int k;
    pulse_start(s);
    if (restart_at > 1) begin
      repeat (restart_at - 1) @(negedge clk);
      start = 1'b1;
      seed = s2;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (!done && k < LAT + 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", done, 1);
    @(negedge clk);
  endtask

  initial begin
    clear_faults();
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    #1;
    chk_idle("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("idle_after_reset");

    run_test(8'h00, -1, 8'h00);
    run_test(8'hA5, -1, 8'h00);

    f_and[5] = 8'hFE;
    f_and[9] = 8'hFE;
    run_test(8'h00, -1, 8'h00);
    clear_faults();
    f_or[5] = 8'h01;
    f_or[9] = 8'h01;
    run_test(8'h00, -1, 8'h00);
    clear_faults();

    run_test(8'h3C, 10, 8'hC3);
    run_test(8'h5A, -1, 8'h00);

    // abort mid-WRITE at address 7
    begin
      int k = 0;
      pulse_start(8'h77);
      while (!(wen && ads == 4'd7) && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("reached_ads7", {wen, ads}, {1'b1, 4'd7});
      rst_n = 1'b0;
      #1;
      chk_idle("async_reset_abort");
      wq.delete();
      rq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk_idle("stays_idle_after_abort");
    end
    run_test(8'h11, -1, 8'h00);

    for (int t = 0; t < 8; t++) begin
      clear_faults();
      if ($urandom_range(1, 0) == 1) begin
        int fa = $urandom_range(DEPTH - 1, 0);
        int fb = $urandom_range(DW - 1, 0);
        if ($urandom_range(1, 0) == 1) f_or[fa][fb] = 1'b1;
        else f_and[fa][fb] = 1'b0;
      end
      run_test(DW'($urandom), ($urandom_range(1, 0) == 1) ? $urandom_range(LAT - 2, 2) : -1, DW'($urandom));
    end
    clear_faults();

    chk("write_queue_drained", wq.size(), 0);
    chk("result_queue_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
